// File: rtl/fp_normalizer_pkg.sv
// Shared definitions for the single-precision ALU datapath stages
// (aligner, normalizer, packer).
package fp_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage

// File: rtl/fp_normalizer_if.sv
// Handshake bundle between the mantissa adder, the normalizer and the packer.
interface fp_normalizer_if #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
);

  // Both sides use strict valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; valid never waits for ready and the
  // payload stays stable while valid is high and ready is low.
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W-1:0] mant_in;
  logic              carry_in;
  logic [EXP_W-1:0]  exp_in;
  logic              sign_in;

  logic              out_valid;
  logic              out_ready;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-2:0] frac_out;
  logic              zero;
  logic              denorm;
  logic              overflow;

  modport master (
    output in_valid, mant_in, carry_in, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, sign_out, exp_out, frac_out, zero, denorm, overflow
  );

  modport slave (
    input  in_valid, mant_in, carry_in, exp_in, sign_in, out_ready,
    output in_ready, out_valid, sign_out, exp_out, frac_out, zero, denorm, overflow
  );

endinterface

// File: rtl/fp_normalizer.sv
// Post-add normalization: renormalizes the adder result one bit position per
// cycle and presents sign/exponent/fraction plus zero/denorm/overflow flags.
module fp_normalizer
  import fp_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  fp_normalizer_if.slave bus,
  output norm_state_t    state_dbg
);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  norm_state_t       state, state_n;
  logic [MANT_W-1:0] mant_r, mant_n;
  logic [EXP_W-1:0]  exp_r, exp_n, exp_inc;
  logic              carry_r, carry_n;
  logic              sign_r, sign_n;
  logic              zero_r, zero_n;
  logic              denorm_r, denorm_n;
  logic              ovf_r, ovf_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_r   <= '0;
      exp_r    <= '0;
      carry_r  <= 1'b0;
      sign_r   <= 1'b0;
      zero_r   <= 1'b0;
      denorm_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      mant_r   <= mant_n;
      exp_r    <= exp_n;
      carry_r  <= carry_n;
      sign_r   <= sign_n;
      zero_r   <= zero_n;
      denorm_r <= denorm_n;
      ovf_r    <= ovf_n;
    end
  end

  always_comb begin
    state_n  = state;
    mant_n   = mant_r;
    exp_n    = exp_r;
    carry_n  = carry_r;
    sign_n   = sign_r;
    zero_n   = zero_r;
    denorm_n = denorm_r;
    ovf_n    = ovf_r;
    exp_inc  = exp_r + EXP_ONE;

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          mant_n   = bus.mant_in;
          carry_n  = bus.carry_in;
          exp_n    = bus.exp_in;
          sign_n   = bus.sign_in;
          zero_n   = 1'b0;
          denorm_n = 1'b0;
          ovf_n    = 1'b0;
          state_n  = NORM;
        end
      end

      NORM: begin
        state_n = DONE;
        // Priority chain: specials, carry, zero, normalized, subnormal, shift.
        if (exp_r == EXP_ONES) begin
          state_n = DONE;
        end else if (carry_r) begin
          mant_n  = {1'b1, mant_r[MANT_W-1:1]};
          exp_n   = exp_inc;
          carry_n = 1'b0;
          if (exp_inc == EXP_ONES) begin
            mant_n[MANT_W-2:0] = '0;
            ovf_n              = 1'b1;
          end
        end else if (mant_r == '0) begin
          exp_n  = '0;
          zero_n = 1'b1;
        end else if (mant_r[MANT_W-1]) begin
          state_n = DONE;
        end else if (exp_r <= EXP_ONE) begin
          exp_n    = '0;
          denorm_n = 1'b1;
        end else begin
          mant_n  = {mant_r[MANT_W-2:0], 1'b0};
          exp_n   = exp_r - EXP_ONE;
          state_n = NORM;
        end
      end

      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sign_out  = sign_r;
  assign bus.exp_out   = exp_r;
  assign bus.frac_out  = mant_r[MANT_W-2:0];
  assign bus.zero      = zero_r;
  assign bus.denorm    = denorm_r;
  assign bus.overflow  = ovf_r;
  assign state_dbg     = state;

endmodule

// File: tb/tb_fp_normalizer.sv
// Randomized and directed bench for fp_normalizer against a behavioural
// leading-zero-count model of the normalization result and latency.
module tb_fp_normalizer;
  import fp_pkg::*;

  localparam int W = 1 + EXP_W + (MANT_W - 1) + 3;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_normalizer_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus();
  norm_state_t state_dbg;

  fp_normalizer #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: leading-zero count decides how far the value can shift before
  // the exponent bottoms out at 1; beyond that the result is subnormal.
  function automatic void model(input logic [MANT_W-1:0] m, input logic c,
                                input logic [EXP_W-1:0] e, input logic s,
                                output logic [W-1:0] res, output int lat);
    logic [MANT_W-1:0] mm;
    int ei, eo, lz, sh;
    logic z, d, o;
    ei = int'(e);
    eo = ei;
    mm = m;
    z = 1'b0; d = 1'b0; o = 1'b0;
    lat = 1;
    if (ei == (1 << EXP_W) - 1) begin
      mm = m;
    end else if (c) begin
      mm = (m >> 1) | {1'b1, {(MANT_W-1){1'b0}}};
      eo = ei + 1;
      if (eo == (1 << EXP_W) - 1) begin
        mm = {1'b1, {(MANT_W-1){1'b0}}};
        o  = 1'b1;
      end
    end else if (m == '0) begin
      eo = 0;
      z  = 1'b1;
    end else begin
      lz = 0;
      for (int i = MANT_W - 1; i >= 0 && !m[i]; i--) lz++;
      if (lz == 0 || lz <= ei - 1) begin
        sh = lz;
        eo = ei - lz;
      end else begin
        sh = (ei > 1) ? ei - 1 : 0;
        eo = 0;
        d  = 1'b1;
      end
      mm  = m << sh;
      lat = sh + 1;
    end
    res = {s, EXP_W'(eo), mm[MANT_W-2:0], z, d, o};
  endfunction

  // scoreboard / compare process
  logic prev_valid = 1'b0;
  int   accept_cyc = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) accept_cyc = cyc + 1;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got out_valid=1 expected none (t=%0t)", $time);
        end else begin
          check("result", 64'({bus.sign_out, bus.exp_out, bus.frac_out,
                               bus.zero, bus.denorm, bus.overflow}), 64'(exp_q[0]));
          check("in_ready_in_done", 64'(bus.in_ready), 64'(0));
          if (!prev_valid) check("latency", 64'(cyc - accept_cyc), 64'(lat_q[0]));
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
      prev_valid = bus.out_valid && !bus.out_ready;
    end
  end

  // driver tasks
  task automatic scramble_inputs();
    bus.mant_in  = MANT_W'($urandom());
    bus.carry_in = 1'($urandom_range(0, 1));
    bus.exp_in   = EXP_W'($urandom());
    bus.sign_in  = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [MANT_W-1:0] m, input logic c,
                      input logic [EXP_W-1:0] e, input logic s, input int hold);
    logic [W-1:0] r;
    int lat, t;
    model(m, c, e, s, r, lat);
    bus.mant_in  = m;
    bus.carry_in = c;
    bus.exp_in   = e;
    bus.sign_in  = s;
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!bus.in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(r);
    lat_q.push_back(lat);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    t = 0;
    while (!bus.out_valid && t < 64) begin
      @(posedge clk); #1; t++;
    end
    if (!bus.out_valid) begin
      n_checks++; n_errors++;
      $display("FAIL output_timeout: got out_valid=0 expected 1");
      exp_q.delete(); lat_q.delete();
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Pins the model itself to hand-computed values before using it.
  task automatic pin(input string name, input logic [MANT_W-1:0] m, input logic c,
                     input logic [EXP_W-1:0] e, input logic [EXP_W-1:0] want_e,
                     input logic [MANT_W-2:0] want_f, input logic [2:0] want_flags,
                     input int want_lat);
    logic [W-1:0] r;
    int lat;
    model(m, c, e, 1'b0, r, lat);
    check({name, "_model"}, 64'(r), 64'({1'b0, want_e, want_f, want_flags}));
    check({name, "_model_lat"}, 64'(lat), 64'(want_lat));
  endtask

  task automatic reset_mid_norm();
    bus.mant_in  = MANT_W'(1);
    bus.carry_in = 1'b0;
    bus.exp_in   = EXP_W'(127);
    bus.sign_in  = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("norm_before_reset", 64'(state_dbg), 64'(NORM));
    check("exp_after_9_shifts", 64'(bus.exp_out), 64'(127 - 9));
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_reset_idle", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    logic [MANT_W-1:0] m;
    logic [EXP_W-1:0]  e;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("reset_outputs", 64'({bus.out_valid, bus.sign_out, bus.exp_out, bus.frac_out,
                                bus.zero, bus.denorm, bus.overflow}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    pin("normalized", 24'h800000, 1'b0, 8'd130, 8'd130, 23'h0, 3'b000, 1);
    pin("carry",      24'h400000, 1'b1, 8'd130, 8'd131, 23'h200000, 3'b000, 1);
    pin("max_shift",  24'h000001, 1'b0, 8'd127, 8'd104, 23'h0, 3'b000, 24);
    pin("subnormal",  24'h000100, 1'b0, 8'd3,   8'd0,   23'h000400, 3'b010, 3);
    pin("overflow",   24'hFFFFFF, 1'b1, 8'd254, 8'd255, 23'h0, 3'b001, 1);
    pin("zero",       24'h000000, 1'b0, 8'd77,  8'd0,   23'h0, 3'b100, 1);
    pin("special",    24'h123456, 1'b1, 8'd255, 8'd255, 23'h123456, 3'b000, 1);

    send(24'h800000, 1'b0, 8'd130, 1'b0, 0);
    send(24'h400000, 1'b1, 8'd130, 1'b1, 1);
    send(24'h000001, 1'b0, 8'd127, 1'b0, 0);
    send(24'h000100, 1'b0, 8'd3,   1'b1, 2);
    send(24'hFFFFFF, 1'b1, 8'd254, 1'b0, 0);
    send(24'h000000, 1'b0, 8'd77,  1'b1, 5);
    send(24'h123456, 1'b1, 8'd255, 1'b0, 0);
    send(24'h0F0000, 1'b0, 8'd200, 1'b0, 5);
    send(24'h800000, 1'b0, 8'd0,   1'b0, 0);
    send(24'h000002, 1'b0, 8'd1,   1'b1, 0);

    for (int i = 0; i < 150; i++) begin
      m = MANT_W'($urandom()) >> $urandom_range(0, MANT_W - 1);
      if ($urandom_range(0, 15) == 0) m = '0;
      case ($urandom_range(0, 3))
        0:       e = EXP_W'($urandom_range(0, 4));
        1:       e = EXP_W'($urandom_range(250, 255));
        default: e = EXP_W'($urandom_range(0, 255));
      endcase
      send(m, ($urandom_range(0, 3) == 0), e, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3));
    end

    reset_mid_norm();
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
